// File: rtl/rr_arbiter_mux_4_1_if.sv
// rtl/rr_arbiter_mux_4_1_if.sv - four-requester valid/ready bus with one registered output channel
interface rr_arbiter_mux_4_1_if #(
    parameter int W = 4
);
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [W-1:0] in_data0;
    logic [W-1:0] in_data1;
    logic [W-1:0] in_data2;
    logic [W-1:0] in_data3;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;

    // master: requesters and consumer side; slave: the arbiter itself
    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        output in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/rr_arbiter_mux_4_1.sv
// rtl/rr_arbiter_mux_4_1.sv - round-robin 4:1 arbiter feeding a one-entry output register
module rr_arbiter_mux_4_1 #(
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_arbiter_mux_4_1_if.slave  bus
);
    logic [1:0]   ptr;
    logic [1:0]   winner;
    logic [1:0]   idx;
    logic         found;
    logic         any_valid;
    logic         can_load;
    logic         transfer;
    logic [W-1:0] mux_data;
    logic         out_valid_q;
    logic [W-1:0] out_data_q;
    logic [1:0]   out_src_q;

    // first valid requester scanning from ptr upward, wrapping mod 4
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && bus.in_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any_valid = |bus.in_valid;
    assign can_load  = !out_valid_q || bus.out_ready;

    always_comb begin
        bus.in_ready = 4'b0000;
        if (!rst && can_load && any_valid) begin
            bus.in_ready = 4'b0001 << winner;
        end
    end

    assign transfer = |(bus.in_valid & bus.in_ready);

    always_comb begin
        case (winner)
            2'd0:    mux_data = bus.in_data0;
            2'd1:    mux_data = bus.in_data1;
            2'd2:    mux_data = bus.in_data2;
            default: mux_data = bus.in_data3;
        endcase
    end

    // a load and a drain in the same cycle keep out_valid high with no bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
            ptr         <= 2'd0;
        end else if (transfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mux_data;
            out_src_q   <= winner;
            ptr         <= winner + 2'd1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_rr_arbiter_mux_4_1.sv
// tb/tb_rr_arbiter_mux_4_1.sv - directed self-checking bench for rr_arbiter_mux_4_1
module tb_rr_arbiter_mux_4_1;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rr_arbiter_mux_4_1_if #(.W(4)) bus ();

    rr_arbiter_mux_4_1 #(.W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 4'b1111;
        bus.out_ready = 1'b1;
        bus.in_data0 = 4'h1; bus.in_data1 = 4'h2; bus.in_data2 = 4'h3; bus.in_data3 = 4'h4;
        tick();
        checks++;
        if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready_c1 got %b exp 0000", bus.in_ready); end
        tick();
        checks++;
        if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready_c2 got %b exp 0000", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++;
        if (bus.out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", bus.out_data); end
        checks++;
        if (bus.out_src !== 2'd0) begin errors++; $display("FAIL reset_out_src got %0d exp 0", bus.out_src); end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b exp 0001", bus.in_ready); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd0 || bus.out_data !== 4'h1) begin
            errors++; $display("FAIL reset_first_word got v=%b src=%0d data=%h exp v=1 src=0 data=1", bus.out_valid, bus.out_src, bus.out_data);
        end
        bus.in_valid = 4'b0000;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_drain got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_single_source();
        bus.in_valid = 4'b0100;
        bus.in_data2 = 4'hA;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL single_in_ready got %b exp 0100", bus.in_ready); end
        tick();
        bus.in_valid = 4'b0000;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hA || bus.out_src !== 2'd2) begin
            errors++; $display("FAIL single_out got v=%b data=%h src=%0d exp v=1 data=a src=2", bus.out_valid, bus.out_data, bus.out_src);
        end
    endtask

    task automatic test_wrap_skip();
        bus.in_data1 = 4'h2;
        bus.in_data3 = 4'h4;
        bus.in_valid = 4'b0010;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0010) begin errors++; $display("FAIL wrap_skip_in_ready got %b exp 0010", bus.in_ready); end
        tick();
        checks++;
        if (bus.out_src !== 2'd1 || bus.out_data !== 4'h2) begin
            errors++; $display("FAIL wrap_skip_out got src=%0d data=%h exp src=1 data=2", bus.out_src, bus.out_data);
        end
        bus.in_valid = 4'b1001;
        #1;
        checks++;
        if (bus.in_ready !== 4'b1000) begin errors++; $display("FAIL wrap_pick3_in_ready got %b exp 1000", bus.in_ready); end
        tick();
        checks++;
        if (bus.out_src !== 2'd3 || bus.out_data !== 4'h4 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_pick3_out got v=%b src=%0d data=%h exp v=1 src=3 data=4", bus.out_valid, bus.out_src, bus.out_data);
        end
        bus.in_valid = 4'b1111;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ptr0 got %b exp 0001", bus.in_ready); end
        bus.in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_rotation();
        logic [1:0] exp_src;
        logic [3:0] exp_data;
        bus.in_data0 = 4'h1; bus.in_data1 = 4'h2; bus.in_data2 = 4'h3; bus.in_data3 = 4'h4;
        bus.out_ready = 1'b1;
        bus.in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_src = 2'(k % 4);
            exp_data = 4'(k % 4 + 1);
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_src !== exp_src || bus.out_data !== exp_data) begin
                errors++; $display("FAIL rotation_%0d got v=%b src=%0d data=%h exp v=1 src=%0d data=%h",
                                   k, bus.out_valid, bus.out_src, bus.out_data, exp_src, exp_data);
            end
        end
        bus.in_valid = 4'b0000;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_src !== 2'd3 || bus.out_data !== 4'h4) begin
            errors++; $display("FAIL rotation_drain got v=%b src=%0d data=%h exp v=0 src=3 data=4", bus.out_valid, bus.out_src, bus.out_data);
        end
    endtask

    task automatic test_backpressure();
        bus.in_valid = 4'b0001;
        bus.in_data0 = 4'h5;
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h5) begin
            errors++; $display("FAIL bp_load got v=%b data=%h exp v=1 data=5", bus.out_valid, bus.out_data);
        end
        bus.in_valid = 4'b1111;
        bus.in_data0 = 4'h9;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready_%0d got %b exp 0000", k, bus.in_ready); end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h5 || bus.out_src !== 2'd0) begin
                errors++; $display("FAIL bp_hold_%0d got v=%b data=%h src=%0d exp v=1 data=5 src=0", k, bus.out_valid, bus.out_data, bus.out_src);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_in_ready got %b exp 0010", bus.in_ready); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h2 || bus.out_src !== 2'd1) begin
            errors++; $display("FAIL bp_no_bubble got v=%b data=%h src=%0d exp v=1 data=2 src=1", bus.out_valid, bus.out_data, bus.out_src);
        end
        bus.in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        int dup_count;
        dup_count = 0;
        bus.in_valid = 4'b0100;
        bus.in_data2 = 4'h7;
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h7 || bus.out_src !== 2'd2) begin
            errors++; $display("FAIL mid_load got v=%b data=%h src=%0d exp v=1 data=7 src=2", bus.out_valid, bus.out_data, bus.out_src);
        end
        bus.out_ready = 1'b0;
        bus.in_valid = 4'b1111;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_in_ready got %b exp 0000", bus.in_ready); end
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.out_src !== 2'd0) begin
            errors++; $display("FAIL mid_rst_state got v=%b data=%h src=%0d exp v=0 data=0 src=0", bus.out_valid, bus.out_data, bus.out_src);
        end
        #1;
        checks++;
        if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL mid_rst_ptr got %b exp 0001", bus.in_ready); end
        bus.in_valid = 4'b0001;
        bus.in_data0 = 4'h3;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 0) bus.in_valid = 4'b0000;
            if (bus.out_valid === 1'b1 && bus.out_data === 4'h7) dup_count++;
        end
        checks++;
        if (dup_count !== 0) begin errors++; $display("FAIL mid_rst_dropped got %0d words of 7 exp 0", dup_count); end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h3) begin
            errors++; $display("FAIL mid_rst_after got v=%b data=%h exp v=0 data=3", bus.out_valid, bus.out_data);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid = 4'b0000;
        bus.out_ready = 1'b0;
        bus.in_data0 = 4'h0; bus.in_data1 = 4'h0; bus.in_data2 = 4'h0; bus.in_data3 = 4'h0;
        test_reset();
        test_single_source();
        test_wrap_skip();
        test_rotation();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
